// File: rtl/rom_loader_bridge.sv
// rom_loader_bridge: buffers ioctl download bytes in a small FIFO, maps the ioctl index
// to an SDRAM base address, and drains one byte per mem_sync slot into the loader port.
// It also keeps overflow, committed-byte and checksum status for the OSD.
module rom_loader_bridge #(
  parameter int unsigned ADDR_W    = 25,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned NUM_SLOTS = 4,
  parameter logic [NUM_SLOTS*ADDR_W-1:0] SLOT_BASE =
    {25'h0, 25'h0, 25'h068000, 25'h080000}
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [DATA_W-1:0] ioctl_dout,
  input  logic              mem_sync,
  output logic              loader_active,
  output logic              loader_we,
  output logic [ADDR_W-1:0] loader_addr,
  output logic [DATA_W-1:0] loader_data,
  output logic              overflow,
  output logic [23:0]       byte_count,
  output logic [15:0]       checksum
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned EW = ADDR_W + DATA_W;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [EW-1:0]     fifo_mem [DEPTH];
  logic [PW:0]       rd_ptr_q, rd_ptr_d;
  logic [PW:0]       wr_ptr_q, wr_ptr_d;
  logic              dl_q;
  logic              active_q, active_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              overflow_q, overflow_d;
  logic [23:0]       count_q, count_d;
  logic [15:0]       sum_q, sum_d;

  logic              accept, push, pop, drop, empty, full, dl_rise;
  logic [ADDR_W-1:0] slot_base;
  logic [EW-1:0]     head, entry;

  // Decode the slot base; only consulted when the index is accepted.
  always_comb begin
    slot_base = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (ioctl_index[5:0] == 6'(i)) slot_base = SLOT_BASE[i*ADDR_W +: ADDR_W];
    end
  end

  // FIFO control, loader slot update and status next-state.
  always_comb begin
    accept  = ioctl_wr && (ioctl_index[7:6] == 2'b00) &&
              ({26'd0, ioctl_index[5:0]} < NUM_SLOTS);
    empty   = (rd_ptr_q == wr_ptr_q);
    full    = (rd_ptr_q[PW] != wr_ptr_q[PW]) && (rd_ptr_q[PW-1:0] == wr_ptr_q[PW-1:0]);
    // Pop looks only at current occupancy, so a same-cycle push into empty waits a slot.
    pop     = mem_sync && !empty;
    push    = accept && (!full || pop);
    drop    = accept && full && !pop;
    dl_rise = ioctl_download && !dl_q;
    head    = fifo_mem[rd_ptr_q[PW-1:0]];
    entry   = {slot_base + ioctl_addr, ioctl_dout};

    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;

    we_d   = mem_sync ? pop : we_q;
    addr_d = addr_q;
    data_d = data_q;
    if (pop) begin
      addr_d = head[EW-1:DATA_W];
      data_d = head[DATA_W-1:0];
    end

    // A download start restarts the totals, but a byte committed in that cycle still counts.
    overflow_d = (dl_rise ? 1'b0 : overflow_q) | drop;
    count_d    = dl_rise ? 24'd0 : count_q;
    sum_d      = dl_rise ? 16'd0 : sum_q;
    if (pop) begin
      count_d = count_d + 24'd1;
      sum_d   = sum_d + 16'(head[DATA_W-1:0]);
    end

    // Derived from next-state values so active drops on the same edge as loader_we.
    active_d = ioctl_download || (wr_ptr_d != rd_ptr_d) || we_d;
  end

  // Control and status registers with synchronous reset.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      dl_q       <= 1'b0;
      active_q   <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      overflow_q <= 1'b0;
      count_q    <= '0;
      sum_q      <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      dl_q       <= ioctl_download;
      active_q   <= active_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      overflow_q <= overflow_d;
      count_q    <= count_d;
      sum_q      <= sum_d;
    end
  end

  // FIFO storage; contents are meaningless outside the pointer window, so no reset.
  always_ff @(posedge clk_sys) begin
    if (push && !reset) fifo_mem[wr_ptr_q[PW-1:0]] <= entry;
  end

  assign loader_active = active_q;
  assign loader_we     = we_q;
  assign loader_addr   = addr_q;
  assign loader_data   = data_q;
  assign overflow      = overflow_q;
  assign byte_count    = count_q;
  assign checksum      = sum_q;

endmodule

// File: tb/tb_rom_loader_bridge.sv
// tb_rom_loader_bridge: directed vectors with hand-computed expectations for the loader bridge.
module tb_rom_loader_bridge;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        mem_sync;
  logic        loader_active;
  logic        loader_we;
  logic [24:0] loader_addr;
  logic [7:0]  loader_data;
  logic        overflow;
  logic [23:0] byte_count;
  logic [15:0] checksum;

  int n_checks = 0;
  int n_errors = 0;
  int we_seen;

  rom_loader_bridge dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .mem_sync       (mem_sync),
    .loader_active  (loader_active),
    .loader_we      (loader_we),
    .loader_addr    (loader_addr),
    .loader_data    (loader_data),
    .overflow       (overflow),
    .byte_count     (byte_count),
    .checksum       (checksum)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are stable 1 ns after the edge.
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
    ioctl_wr    = 1'b1;
    ioctl_index = idx;
    ioctl_addr  = a;
    ioctl_dout  = d;
    tick();
    ioctl_wr    = 1'b0;
  endtask

  task automatic sync();
    mem_sync = 1'b1;
    tick();
    mem_sync = 1'b0;
  endtask

  // Drop then raise download to restart the status totals.
  task automatic restart();
    ioctl_download = 1'b0;
    idle(2);
    ioctl_download = 1'b1;
    tick();
  endtask

  initial begin
    reset = 1'b1; ioctl_download = 1'b0; ioctl_index = '0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0; mem_sync = 1'b0;
    idle(3);
    reset = 1'b0;
    tick();

    // Reset state and idle syncs
    check("rst_we", loader_we, 0);
    check("rst_active", loader_active, 0);
    check("rst_addr", loader_addr, 0);
    check("rst_data", loader_data, 0);
    check("rst_ovf", overflow, 0);
    check("rst_cnt", byte_count, 0);
    check("rst_sum", checksum, 0);
    we_seen = 0;
    for (int i = 0; i < 10; i++) begin
      sync();
      if (loader_we) we_seen++;
      idle(3);
    end
    check("idle_we", we_seen, 0);

    // Slot 0 byte, mem_sync every 16 clocks
    ioctl_download = 1'b1;
    tick();
    push(8'd0, 25'h000010, 8'hA5);
    sync();
    check("s0_we", loader_we, 1);
    check("s0_addr", loader_addr, 32'h080010);
    check("s0_data", loader_data, 8'hA5);
    check("s0_cnt", byte_count, 1);
    check("s0_sum", checksum, 16'h00A5);
    check("s0_active", loader_active, 1);
    idle(15);
    check("s0_we_hold", loader_we, 1);
    sync();
    check("s0_we_clr", loader_we, 0);
    check("s0_addr_hold", loader_addr, 32'h080010);

    // Slot 1 base and rejected indices
    push(8'd1, 25'h003FFF, 8'h5A);
    sync();
    check("s1_addr", loader_addr, 32'h06BFFF);
    check("s1_data", loader_data, 8'h5A);
    check("s1_sum", checksum, 16'h00FF);
    push(8'h40, 25'h000001, 8'h11);
    push(8'd5, 25'h000002, 8'h22);
    sync();
    check("rej_we", loader_we, 0);
    check("rej_ovf", overflow, 0);
    check("rej_cnt", byte_count, 2);

    // Overflow: 6 pushes into a 4-deep FIFO
    restart();
    check("restart_cnt", byte_count, 0);
    for (int i = 0; i < 6; i++) push(8'd2, 25'h100 + 25'(i), 8'h10 + 8'(i));
    check("ovf_set", overflow, 1);
    for (int i = 0; i < 4; i++) begin
      sync();
      check("ovf_we", loader_we, 1);
      check("ovf_addr", loader_addr, 32'h100 + 32'(i));
      check("ovf_data", loader_data, 8'h10 + 8'(i));
      idle(2);
    end
    sync();
    check("ovf_drain_we", loader_we, 0);
    check("ovf_cnt", byte_count, 4);
    check("ovf_sum", checksum, 16'h0046);
    check("ovf_sticky", overflow, 1);

    // Full FIFO: push and pop in the same cycle
    restart();
    check("full_ovf_clr", overflow, 0);
    for (int i = 0; i < 4; i++) push(8'd2, 25'h200 + 25'(i), 8'h20 + 8'(i));
    ioctl_wr = 1'b1; ioctl_index = 8'd2; ioctl_addr = 25'h204; ioctl_dout = 8'h24;
    mem_sync = 1'b1;
    tick();
    ioctl_wr = 1'b0; mem_sync = 1'b0;
    check("full_ovf", overflow, 0);
    check("full_data", loader_data, 8'h20);
    push(8'd2, 25'h299, 8'h99);
    check("full_still", overflow, 1);
    for (int i = 1; i < 5; i++) begin
      sync();
      check("full_addr", loader_addr, 32'h200 + 32'(i));
      check("full_data_n", loader_data, 8'h20 + 8'(i));
    end
    sync();
    check("full_drain_we", loader_we, 0);

    // loader_active tail after download falls
    restart();
    for (int i = 0; i < 3; i++) push(8'd3, 25'h300 + 25'(i), 8'h01 + 8'(i));
    ioctl_download = 1'b0;
    tick();
    check("tail_active0", loader_active, 1);
    for (int i = 0; i < 3; i++) begin
      sync();
      check("tail_we", loader_we, 1);
      check("tail_data", loader_data, 8'h01 + 8'(i));
      idle(3);
      check("tail_active", loader_active, 1);
    end
    sync();
    check("tail_we_off", loader_we, 0);
    check("tail_active_off", loader_active, 0);
    check("tail_cnt", byte_count, 3);
    check("tail_sum", checksum, 16'h0006);

    // Reset with queued entries
    ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) push(8'd0, 25'h400 + 25'(i), 8'h70 + 8'(i));
    reset = 1'b1; ioctl_download = 1'b0;
    tick();
    reset = 1'b0;
    check("rq_we", loader_we, 0);
    check("rq_active", loader_active, 0);
    check("rq_cnt", byte_count, 0);
    we_seen = 0;
    for (int i = 0; i < 5; i++) begin
      sync();
      if (loader_we) we_seen++;
    end
    check("rq_no_writes", we_seen, 0);
    check("rq_active_end", loader_active, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
